uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 29 ++
 rtl/sync_2ff.sv | 34 +++
 rtl/uart_rx.sv | 214 +++++++++++++++++++++
 tb/tb_uart_rx.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants and FSM state encodings for the UART
//               receiver (data width, state codes, parity helper).
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Number of data bits in every frame
  localparam int DataBits = 8;

  // Receiver FSM state encoding (PARITY only reachable in the parity build)
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } uart_state_t;

  // Even parity bit for a data byte: the bit that makes the total ones count even
  function automatic logic even_parity(input logic [DataBits-1:0] d);
    return ^d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer for a single asynchronous input, with
//               a configurable value loaded by asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture of the asynchronous input; both stages reset to RESET_VAL
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : UART receiver, 8N1 by default. Start-bit glitch rejection,
//               mid-bit sampling, one-cycle valid / frame_error /
//               parity_error pulses and break (held-low line) handling.
//               Build option: define UART_RX_PARITY_EN for 8E1 framing with
//               an even parity bit checked before the stop bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int ClksPerBit = 434,
  parameter int HalfBit    = ClksPerBit / 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx,
  output logic [DataBits-1:0] data,
  output logic                valid,
  output logic                frame_error,
  output logic                parity_error,
  output logic                busy
);

  localparam int CntW = $clog2(ClksPerBit);
  localparam int IdxW = $clog2(DataBits);

  localparam logic [CntW-1:0] c_cnt_full = CntW'(ClksPerBit - 1);
  localparam logic [CntW-1:0] c_cnt_half = CntW'(HalfBit - 1);
  localparam logic [IdxW-1:0] c_last_idx = IdxW'(DataBits - 1);

  uart_state_t         r_state;
  uart_state_t         w_state_next;
  logic [CntW-1:0]     r_cnt;
  logic [CntW-1:0]     w_cnt_next;
  logic [IdxW-1:0]     r_idx;
  logic [IdxW-1:0]     w_idx_next;
  logic [DataBits-1:0] r_shift;
  logic [DataBits-1:0] w_shift_next;
  logic [DataBits-1:0] r_data;
  logic                r_valid;
  logic                r_ferr;
  logic                w_rxs;
  logic                w_tick;
  logic                w_par_bad;
  logic                w_stop_done;
  logic                w_valid_set;
  logic                w_ferr_set;

`ifdef UART_RX_PARITY_EN
  logic                r_par_bad;
  logic                w_par_bad_next;
  logic                r_perr;
  logic                w_perr_set;
`endif

  // Bring the serial line into the clock domain; idle level is high
  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync_rx (
    .clk (clk),
    .rst (reset),
    .i_d (rx),
    .o_q (w_rxs)
  );

  assign w_tick = (r_cnt == '0);

`ifdef UART_RX_PARITY_EN
  assign w_par_bad = r_par_bad;
`else
  assign w_par_bad = 1'b0;
`endif

  // State register together with the bit timer, bit index and shift register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
`ifdef UART_RX_PARITY_EN
      r_par_bad <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_idx     <= w_idx_next;
      r_shift   <= w_shift_next;
`ifdef UART_RX_PARITY_EN
      r_par_bad <= w_par_bad_next;
`endif
    end
  end

  // Next-state and datapath decisions, all taken on the synchronized line
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = w_tick ? '0 : (r_cnt - CntW'(1));
    w_idx_next     = r_idx;
    w_shift_next   = r_shift;
`ifdef UART_RX_PARITY_EN
    w_par_bad_next = r_par_bad;
`endif
    case (r_state)
      S_IDLE: begin
        // Falling edge: time half a bit to land in the middle of the start bit
        if (!w_rxs) begin
          w_state_next   = S_START;
          w_cnt_next     = c_cnt_half;
`ifdef UART_RX_PARITY_EN
          w_par_bad_next = 1'b0;
`endif
        end
      end
      S_START: begin
        // Line back high at mid start bit means a glitch: drop it silently
        if (w_tick) begin
          if (!w_rxs) begin
            w_state_next = S_DATA;
            w_cnt_next   = c_cnt_full;
            w_idx_next   = '0;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      S_DATA: begin
        // LSB arrives first, so shift right and insert at the top
        if (w_tick) begin
          w_shift_next = {w_rxs, r_shift[DataBits-1:1]};
          w_cnt_next   = c_cnt_full;
          if (r_idx == c_last_idx) begin
`ifdef UART_RX_PARITY_EN
            w_state_next = S_PARITY;
`else
            w_state_next = S_STOP;
`endif
          end else begin
            w_idx_next = r_idx + IdxW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_tick) begin
          w_par_bad_next = (w_rxs != even_parity(r_shift));
          w_cnt_next     = c_cnt_full;
          w_state_next   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        // A low stop bit is treated as a break; wait there for the line to recover
        if (w_tick) begin
          w_state_next = w_rxs ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: begin
        if (w_rxs) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Frame outcome decode at mid stop bit; frame error takes precedence
  always_comb begin
    w_stop_done = (r_state == S_STOP) && w_tick;
    w_valid_set = w_stop_done && w_rxs && !w_par_bad;
    w_ferr_set  = w_stop_done && !w_rxs;
`ifdef UART_RX_PARITY_EN
    w_perr_set  = w_stop_done && w_rxs && w_par_bad;
`endif
    busy        = (r_state != S_IDLE);
  end

  // Registered result pulses; data only changes together with valid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr  <= 1'b0;
`endif
    end else begin
      r_valid <= w_valid_set;
      r_ferr  <= w_ferr_set;
`ifdef UART_RX_PARITY_EN
      r_perr  <= w_perr_set;
`endif
      if (w_valid_set) begin
        r_data <= r_shift;
      end
    end
  end

  assign data        = r_data;
  assign valid       = r_valid;
  assign frame_error = r_ferr;
`ifdef UART_RX_PARITY_EN
  assign parity_error = r_perr;
`else
  assign parity_error = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx at 16 clocks per bit.
//               Directed sequences, a table of frames and random frames are
//               compared against an event-level expectation queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int CPB     = 16;
  localparam int K_VALID = 0;
  localparam int K_FE    = 1;
  localparam int K_PE    = 2;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // Falling edge to valid: 2 sync + 8 to mid start bit + remaining bit cells + 1
  localparam int LAT = 2 + 8 + (FRAME_BITS - 1) * CPB + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_error;
  logic       parity_error;
  logic       busy;

  uart_rx #(
    .ClksPerBit (CPB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .data         (data),
    .valid        (valid),
    .frame_error  (frame_error),
    .parity_error (parity_error),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;
    logic [7:0] d;
    int         cyc;
  } ev_t;

  typedef struct {
    logic [7:0] d;
    logic       stop;
    int         gap;
    int         exp_kind;
    logic [7:0] exp_d;
  } vec_t;

  ev_t        obs_q[$];
  ev_t        exp_q[$];
  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  logic [7:0] prev_data  = 8'h00;
  logic       prev_pulse = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Output monitor: collects result pulses and checks pulse shape and data hold
  always @(posedge clk) begin
    ev_t e;
    cyc = cyc + 1;
    #1;
    if (valid || frame_error || parity_error) begin
      e.kind = valid ? K_VALID : (frame_error ? K_FE : K_PE);
      e.d    = data;
      e.cyc  = cyc;
      obs_q.push_back(e);
      chk("one_hot_pulse", int'(valid) + int'(frame_error) + int'(parity_error), 1);
      chk("pulse_width", int'(prev_pulse), 0);
    end
    if (!reset && !valid && data !== prev_data) begin
      total++;
      bad++;
      $display("FAIL data_hold: got 0x%0h expected 0x%0h", data, prev_data);
    end
    prev_data  = data;
    prev_pulse = valid | frame_error | parity_error;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bitcell(input logic v);
    rx = v;
    step(CPB);
  endtask

  task automatic send_head(input logic [7:0] d, input logic par_ok);
    bitcell(1'b0);
    for (int i = 0; i < 8; i++) bitcell(d[i]);
`ifdef UART_RX_PARITY_EN
    bitcell(par_ok ? ^d : ~^d);
`else
    if (!par_ok) $display("note: parity request ignored in 8N1 build");
`endif
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input logic par_ok, input int gap);
    send_head(d, par_ok);
    bitcell(stop_bit);
    rx = 1'b1;
    step(gap);
  endtask

  task automatic expect_ev(input int kind, input logic [7:0] d);
    ev_t e;
    e.kind = kind;
    e.d    = d;
    e.cyc  = 0;
    exp_q.push_back(e);
  endtask

  // Reference outcome of a frame from its bits alone
  task automatic model_frame(input logic [7:0] d, input logic stop_bit, input logic par_ok);
    if (!stop_bit)    expect_ev(K_FE, 8'h00);
    else if (!par_ok) expect_ev(K_PE, 8'h00);
    else              expect_ev(K_VALID, d);
  endtask

  task automatic check_events(input string name);
    int n;
    step(20);
    chk({name, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({name, "_kind"}, obs_q[i].kind, exp_q[i].kind);
      if (exp_q[i].kind == K_VALID) chk({name, "_data"}, int'(obs_q[i].d), int'(exp_q[i].d));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   t0;
    vec_t tbl[6];
    logic [7:0] rd;
    logic       rstop;
    logic       rpar;
    int         rgap;

    reset = 1'b1;
    rx    = 1'b1;
    step(3);
    chk("rst_data",  int'(data), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_ferr",  int'(frame_error), 0);
    chk("rst_perr",  int'(parity_error), 0);
    chk("rst_busy",  int'(busy), 0);
    reset = 1'b0;
    step(5);

    // Single frame with latency measurement
    t0 = cyc;
    send_frame(8'h41, 1'b1, 1'b1, 0);
    expect_ev(K_VALID, 8'h41);
    if (obs_q.size() > 0) chk("latency", obs_q[0].cyc - t0, LAT);
    else                  chk("latency", -1, LAT);
    check_events("frame41");
    chk("busy_after41", int'(busy), 0);
    chk("data_after41", int'(data), 8'h41);

    // Short low glitch must be rejected
    t0 = cyc;
    rx = 1'b0;
    step(4);
    rx = 1'b1;
    chk("glitch_busy_hi", int'(busy), 1);
    step(11 - (cyc - t0));
    chk("glitch_busy_lo", int'(busy), 0);
    check_events("glitch");

    // Bad stop bit followed by a held-low line
    send_head(8'h55, 1'b1);
    rx = 1'b0;
    step(CPB);
    expect_ev(K_FE, 8'h00);
    step(40);
    chk("break_busy", int'(busy), 1);
    chk("break_data", int'(data), 8'h41);
    check_events("break");
    rx = 1'b1;
    step(5);
    chk("break_exit_busy", int'(busy), 0);

    // Back-to-back frames with no idle gap
    send_frame(8'h33, 1'b1, 1'b1, 0);
    send_frame(8'h41, 1'b1, 1'b1, 0);
    send_frame(8'h0D, 1'b1, 1'b1, 0);
    expect_ev(K_VALID, 8'h33);
    expect_ev(K_VALID, 8'h41);
    expect_ev(K_VALID, 8'h0D);
    check_events("b2b");
    chk("b2b_data", int'(data), 8'h0D);

    // Asynchronous reset in the middle of the data bits of 0x12
    bitcell(1'b0);
    bitcell(1'b0);
    bitcell(1'b1);
    bitcell(1'b0);
    chk("mid_busy", int'(busy), 1);
    #3 reset = 1'b1;
    #1;
    chk("async_rst_data",  int'(data), 0);
    chk("async_rst_valid", int'(valid), 0);
    chk("async_rst_ferr",  int'(frame_error), 0);
    chk("async_rst_perr",  int'(parity_error), 0);
    chk("async_rst_busy",  int'(busy), 0);
    @(posedge clk);
    #1;
    rx = 1'b0;
    step(3);
    reset = 1'b0;
    send_frame(8'h7E, 1'b1, 1'b1, 4);
    expect_ev(K_VALID, 8'h7E);
    check_events("after_rst");
    chk("after_rst_data", int'(data), 8'h7E);

`ifdef UART_RX_PARITY_EN
    // Parity: 0x07 has three ones, so the even parity bit is 1
    send_frame(8'h07, 1'b1, 1'b0, 2);
    expect_ev(K_PE, 8'h00);
    send_frame(8'h07, 1'b1, 1'b1, 2);
    expect_ev(K_VALID, 8'h07);
    check_events("parity");
    chk("parity_data", int'(data), 8'h07);
`endif

    // Table of frames with expected outcomes
    tbl[0] = '{8'h00, 1'b1, 0, K_VALID, 8'h00};
    tbl[1] = '{8'hFF, 1'b1, 1, K_VALID, 8'hFF};
    tbl[2] = '{8'hA5, 1'b0, 3, K_FE,    8'h00};
    tbl[3] = '{8'h5A, 1'b1, 0, K_VALID, 8'h5A};
    tbl[4] = '{8'h80, 1'b1, 7, K_VALID, 8'h80};
    tbl[5] = '{8'h01, 1'b1, 0, K_VALID, 8'h01};
    for (int i = 0; i < 6; i++) begin
      send_frame(tbl[i].d, tbl[i].stop, 1'b1, tbl[i].gap);
      expect_ev(tbl[i].exp_kind, tbl[i].exp_d);
    end
    check_events("table");

    // Random frames against the reference model
    for (int i = 0; i < 24; i++) begin
      rd    = 8'($urandom);
      rstop = ($urandom_range(0, 4) != 0);
`ifdef UART_RX_PARITY_EN
      rpar  = ($urandom_range(0, 3) != 0);
`else
      rpar  = 1'b1;
`endif
      rgap  = rstop ? int'($urandom_range(0, 12)) : int'($urandom_range(2, 12));
      send_frame(rd, rstop, rpar, rgap);
      model_frame(rd, rstop, rpar);
    end
    check_events("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
